cr_tlvp_ord_mrg: RTL and testbench
==================================

// Module: cr_tlvp_ord_mrg
// PURPOSE
//  Re-merges the TLVP passthrough and user inbound streams into one ordered TLV stream.
//  The TLVP splitter stamps every non-deleted TLV with an order number: 1 at frame
//  start, +1 per kept TLV. This block sits downstream of both inbound FIFOs. It
//  forwards whole TLVs from whichever FIFO head carries the expected order number.
//  Output is a registered single-entry stage with a valid/ready handshake.
// PARAMETERS
//  WDOG_CYCLES  1024  stall cycles before watchdog error; used only with the watchdog macro
//  WDOG_W       16    watchdog counter width; WDOG_CYCLES < 2**WDOG_W
// PORTS
//  clk                input   1                  clock
//  rst_n              input   1                  asynchronous reset, active-low
//  pt_ob_empty        input   1                  passthrough FIFO empty
//  pt_ob_rdata        input   tlvp_if_bus_t      passthrough FIFO head word
//  pt_ob_rd           output  1                  passthrough FIFO pop
//  usr_ob_empty       input   1                  user FIFO empty
//  usr_ob_rdata       input   tlvp_if_bus_t      user FIFO head word
//  usr_ob_rd          output  1                  user FIFO pop
//  tlvp_out_valid     output  1                  output word valid
//  tlvp_out_ready     input   1                  downstream accepts word
//  tlvp_out           output  tlvp_if_bus_t      merged output word
//  tlvp_mrg_err       output  1                  one-cycle pulse: order conflict
//  tlvp_mrg_wdog_err  output  1                  sticky watchdog flag; tied 0 without the macro
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=SEL, exp_ord=`TLVP_ORD_NUM_WIDTH'd1. All outputs 0.
//  - FSM states: SEL, FWD_PT, FWD_USR.
//  - SEL: no pops.
//    - If pt non-empty and pt head ordern==exp_ord, go to FWD_PT next cycle.
//    - Else if usr non-empty and usr head ordern==exp_ord, go to FWD_USR.
//    - Both heads match: go to FWD_PT and pulse tlvp_mrg_err.
//    - Neither matches: stay in SEL; this is the normal wait for user-side processing.
//  - FWD_x pop condition: pop = !x_empty & (!tlvp_out_valid | tlvp_out_ready).
//    - The popped word is loaded into the output register in the same cycle.
//    - tlvp_out_valid=1 the following cycle.
//  - Output register: holds word and valid until tlvp_out_ready=1.
//    - Back-to-back throughput is 1 word/cycle while ready=1.
//  - Latency: matching head present in SEL -> first word on tlvp_out 2 cycles later.
//  - TLV end:
//    - Popped word with tlast=1: exp_ord<=1, next state SEL.
//    - Else popped word with eot=1: exp_ord<=exp_ord+1, next state SEL.
//    - tlast has priority over eot.
//  - exp_ord wraps modulo 2**`TLVP_ORD_NUM_WIDTH. No saturation; the 0 value after wrap is legal.
//  - Mid-TLV empty source: stay in FWD_x with no pop. The other source is never read mid-TLV.
//  - In SEL, a non-empty head with ordern!=exp_ord and first-word ordern<exp_ord
//    (unsigned, non-wrapped) pulses tlvp_mrg_err once per SEL entry. Then keep waiting.
//  - Reset mid-TLV: state and exp_ord clear immediately. FIFOs are not drained by this block.
// CONFIGURATION
//  CR_TLVP_MRG_WDOG_EN defined:
//    - Counter increments each cycle in SEL with at least one source non-empty and no match.
//    - Counter clears on leaving SEL.
//    - Counter reaching WDOG_CYCLES sets tlvp_mrg_wdog_err until reset. Merging continues.
//  CR_TLVP_MRG_WDOG_EN undefined: no counter logic; tlvp_mrg_wdog_err constant 0.
// TESTING
//  - T1 ordering: pt holds ord1 (3 words, eot on 3rd) and ord3; usr holds ord2 (2 words).
//    -> Output ord1, ord2, ord3 in that order; 6 pops total; exp_ord=4 at end.
//  - T2 tlast:
//    - pt ord1 (1 word, eot), then usr ord2 (tlast=1), then pt ord1 of the next frame.
//    - -> exp_ord 1->2->1; three TLVs emitted; no err.
//  - T3 backpressure: ready=0 for 5 cycles mid-TLV.
//    -> Output word held stable; no pops while valid & !ready; no word lost or duplicated.
//  - T4 conflict: pt and usr heads both ordern=1 in SEL.
//    -> Single-cycle tlvp_mrg_err; pt TLV forwarded first.
//  - T5 stall/watchdog (macro on, WDOG_CYCLES=8): only usr non-empty with ordern=5, exp_ord=4.
//    -> No pops; tlvp_mrg_wdog_err=1 at 8th stall cycle and stays 1.
//    -> Macro off: stays 0.
//  - T6 reset mid-TLV: rst_n low during 2nd word of ord2.
//    -> Outputs 0 asynchronously; after release state=SEL, exp_ord=1.

Source files
------------

// File: rtl/cr_tlvp_ord_mrg.sv
// cr_tlvp_ord_mrg
// Purpose: re-merges the TLVP passthrough and user inbound streams into one
//   ordered TLV stream. Every kept TLV carries an order number (1 at frame
//   start, +1 per TLV). Whole TLVs are forwarded from whichever FIFO head
//   carries the expected order number, through a registered single-entry
//   output stage with a valid/ready handshake.
// Optional feature: define CR_TLVP_MRG_WDOG_EN to build the stall watchdog.
//   Without it tlvp_mrg_wdog_err is tied to 0 and no counter is built.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pt_ob_empty/rdata   passthrough FIFO empty flag and head word
//   pt_ob_rd            passthrough FIFO pop
//   usr_ob_empty/rdata  user FIFO empty flag and head word
//   usr_ob_rd           user FIFO pop
//   tlvp_out_valid      output word valid
//   tlvp_out_ready      downstream accepts word
//   tlvp_out            merged output word
//   tlvp_mrg_err        one-cycle pulse on order conflict or stale head
//   tlvp_mrg_wdog_err   sticky watchdog flag

`ifndef TLVP_ORD_NUM_WIDTH
`define TLVP_ORD_NUM_WIDTH 8
`endif

package cr_tlvp_ord_mrg_pkg;
  localparam int OrdW = `TLVP_ORD_NUM_WIDTH;

  typedef struct packed {
    logic [31:0]     tdata;
    logic [OrdW-1:0] ordern;
    logic            eot;
    logic            tlast;
  } tlvp_if_bus_t;
endpackage

module cr_tlvp_ord_mrg
  import cr_tlvp_ord_mrg_pkg::*;
#(
  parameter int WDOG_CYCLES = 1024,
  parameter int WDOG_W      = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pt_ob_empty,
  input  tlvp_if_bus_t pt_ob_rdata,
  output logic         pt_ob_rd,
  input  logic         usr_ob_empty,
  input  tlvp_if_bus_t usr_ob_rdata,
  output logic         usr_ob_rd,
  output logic         tlvp_out_valid,
  input  logic         tlvp_out_ready,
  output tlvp_if_bus_t tlvp_out,
  output logic         tlvp_mrg_err,
  output logic         tlvp_mrg_wdog_err
);

  typedef enum logic [1:0] {SEL, FWD_PT, FWD_USR} state_e;

  state_e          state_q;
  logic [OrdW-1:0] expOrd_q;
  logic            selErrDone_q;
  logic            mrgErr_q;
  logic            outValid_q;
  logic            outValid_d;
  tlvp_if_bus_t    outWord_q;
  tlvp_if_bus_t    outWord_d;

  logic            ptMatch;
  logic            usrMatch;
  logic            staleHead;
  logic            outFree;
  logic            popAny;
  tlvp_if_bus_t    popWord;

  assign ptMatch  = !pt_ob_empty  && (pt_ob_rdata.ordern  == expOrd_q);
  assign usrMatch = !usr_ob_empty && (usr_ob_rdata.ordern == expOrd_q);

  // A head below the expected number can never be forwarded this frame.
  assign staleHead = (!pt_ob_empty  && (pt_ob_rdata.ordern  < expOrd_q)) ||
                     (!usr_ob_empty && (usr_ob_rdata.ordern < expOrd_q));

  assign outFree   = !outValid_q || tlvp_out_ready;
  assign pt_ob_rd  = (state_q == FWD_PT)  && !pt_ob_empty  && outFree;
  assign usr_ob_rd = (state_q == FWD_USR) && !usr_ob_empty && outFree;
  assign popAny    = pt_ob_rd || usr_ob_rd;
  assign popWord   = pt_ob_rd ? pt_ob_rdata : usr_ob_rdata;

  // Output stage: a pop always lands in the register in the same cycle,
  // otherwise the word is held until the consumer takes it.
  always_comb begin
    outWord_d  = outWord_q;
    outValid_d = outValid_q;
    if (popAny) begin
      outWord_d  = popWord;
      outValid_d = 1'b1;
    end else if (tlvp_out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outWord_q  <= '0;
      outValid_q <= 1'b0;
    end else begin
      outWord_q  <= outWord_d;
      outValid_q <= outValid_d;
    end
  end

  // Selection FSM: picks a source in SEL, then stays on it until the TLV ends.
  // The stale-head error is reported at most once per visit to SEL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SEL;
      expOrd_q     <= OrdW'(1);
      selErrDone_q <= 1'b0;
      mrgErr_q     <= 1'b0;
    end else begin
      mrgErr_q <= 1'b0;
      case (state_q)
        SEL: begin
          if (ptMatch) begin
            state_q      <= FWD_PT;
            mrgErr_q     <= usrMatch;
            selErrDone_q <= 1'b0;
          end else if (usrMatch) begin
            state_q      <= FWD_USR;
            selErrDone_q <= 1'b0;
          end else if (staleHead && !selErrDone_q) begin
            mrgErr_q     <= 1'b1;
            selErrDone_q <= 1'b1;
          end
        end
        FWD_PT, FWD_USR: begin
          if (popAny && popWord.tlast) begin
            state_q  <= SEL;
            expOrd_q <= OrdW'(1);
          end else if (popAny && popWord.eot) begin
            state_q  <= SEL;
            expOrd_q <= expOrd_q + OrdW'(1);
          end
        end
        default: state_q <= SEL;
      endcase
    end
  end

  assign tlvp_out_valid = outValid_q;
  assign tlvp_out       = outWord_q;
  assign tlvp_mrg_err   = mrgErr_q;

`ifdef CR_TLVP_MRG_WDOG_EN
  localparam logic [WDOG_W-1:0] WdogLimit   = WDOG_W'(WDOG_CYCLES);
  localparam logic [WDOG_W-1:0] WdogLimitM1 = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdogCnt_q;
  logic              wdogErr_q;
  logic              stall;

  assign stall = (state_q == SEL) && !(pt_ob_empty && usr_ob_empty) &&
                 !ptMatch && !usrMatch;

  // Stall counter saturates at the limit; the flag stays set until reset
  // while merging carries on normally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdogCnt_q <= '0;
      wdogErr_q <= 1'b0;
    end else begin
      if (state_q != SEL) begin
        wdogCnt_q <= '0;
      end else if (stall && (wdogCnt_q != WdogLimit)) begin
        wdogCnt_q <= wdogCnt_q + WDOG_W'(1);
      end
      if (stall && (wdogCnt_q == WdogLimitM1)) begin
        wdogErr_q <= 1'b1;
      end
    end
  end

  assign tlvp_mrg_wdog_err = wdogErr_q;
`else
  logic unusedWdogParams;
  assign unusedWdogParams  = ^{WDOG_CYCLES, WDOG_W};
  assign tlvp_mrg_wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_cr_tlvp_ord_mrg.sv
// Testbench for cr_tlvp_ord_mrg: behavioural FIFO models feed both inputs,
// a table of single-step selection vectors plus hand-written TLV sequences.
module tb_cr_tlvp_ord_mrg;
  import cr_tlvp_ord_mrg_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pt_ob_empty;
  tlvp_if_bus_t pt_ob_rdata;
  logic         pt_ob_rd;
  logic         usr_ob_empty;
  tlvp_if_bus_t usr_ob_rdata;
  logic         usr_ob_rd;
  logic         tlvp_out_valid;
  logic         tlvp_out_ready;
  tlvp_if_bus_t tlvp_out;
  logic         tlvp_mrg_err;
  logic         tlvp_mrg_wdog_err;

  int checks = 0;
  int errors = 0;
  int popCount;
  int errPulses;

  tlvp_if_bus_t ptQ[$];
  tlvp_if_bus_t usrQ[$];
  tlvp_if_bus_t rxQ[$];
  tlvp_if_bus_t expQ[$];

  typedef struct {
    logic            ptHas;
    logic [OrdW-1:0] ptOrd;
    logic            usrHas;
    logic [OrdW-1:0] usrOrd;
    logic            expPtRd;
    logic            expUsrRd;
    logic            expErr;
  } vec_t;

  vec_t vecs[7];

  cr_tlvp_ord_mrg #(.WDOG_CYCLES(8), .WDOG_W(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pt_ob_empty       (pt_ob_empty),
    .pt_ob_rdata       (pt_ob_rdata),
    .pt_ob_rd          (pt_ob_rd),
    .usr_ob_empty      (usr_ob_empty),
    .usr_ob_rdata      (usr_ob_rdata),
    .usr_ob_rd         (usr_ob_rd),
    .tlvp_out_valid    (tlvp_out_valid),
    .tlvp_out_ready    (tlvp_out_ready),
    .tlvp_out          (tlvp_out),
    .tlvp_mrg_err      (tlvp_mrg_err),
    .tlvp_mrg_wdog_err (tlvp_mrg_wdog_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic tlvp_if_bus_t mkWord(input int ord, input int data,
                                          input bit eot, input bit tlast);
    tlvp_if_bus_t w;
    w.tdata  = 32'(data);
    w.ordern = OrdW'(ord);
    w.eot    = eot;
    w.tlast  = tlast;
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic updateHeads();
    pt_ob_empty  = (ptQ.size() == 0);
    pt_ob_rdata  = (ptQ.size() == 0) ? '0 : ptQ[0];
    usr_ob_empty = (usrQ.size() == 0);
    usr_ob_rdata = (usrQ.size() == 0) ? '0 : usrQ[0];
  endtask

  // One clock: sample handshakes before the edge, apply FIFO pops after it,
  // and return at the following falling edge.
  task automatic tick();
    logic ptRdS, usrRdS;
    tlvp_if_bus_t tmp;
    #1;
    ptRdS  = pt_ob_rd;
    usrRdS = usr_ob_rd;
    if (tlvp_out_valid && tlvp_out_ready) rxQ.push_back(tlvp_out);
    if (tlvp_mrg_err) errPulses++;
    @(posedge clk);
    #1;
    if (ptRdS) begin
      if (ptQ.size() == 0) checkOutput("pt_pop_on_empty", 64'd1, 64'd0);
      else tmp = ptQ.pop_front();
      popCount++;
    end
    if (usrRdS) begin
      if (usrQ.size() == 0) checkOutput("usr_pop_on_empty", 64'd1, 64'd0);
      else tmp = usrQ.pop_front();
      popCount++;
    end
    updateHeads();
    @(negedge clk);
  endtask

  task automatic assertReset();
    rst_n = 1'b0;
    tlvp_out_ready = 1'b1;
    ptQ.delete();
    usrQ.delete();
    rxQ.delete();
    expQ.delete();
    popCount  = 0;
    errPulses = 0;
    updateHeads();
  endtask

  task automatic releaseReset();
    updateHeads();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runUntil(input int n, input int budget);
    for (int c = 0; c < budget && rxQ.size() < n; c++) tick();
  endtask

  task automatic compareRx(input string name);
    checkOutput({name, "_count"}, 64'(rxQ.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++)
      checkOutput(name, (i < rxQ.size()) ? 64'(rxQ[i]) : 64'h0, 64'(expQ[i]));
  endtask

  // One selection decision from a fresh reset (expected order number 1).
  task automatic applyStimulus(input vec_t v, input int idx);
    assertReset();
    if (v.ptHas)  ptQ.push_back(mkWord(v.ptOrd, 32'h100 + idx, 1'b1, 1'b0));
    if (v.usrHas) usrQ.push_back(mkWord(v.usrOrd, 32'h200 + idx, 1'b1, 1'b0));
    releaseReset();
    tick();
    checkOutput($sformatf("vec%0d_pt_rd", idx), 64'(pt_ob_rd), 64'(v.expPtRd));
    checkOutput($sformatf("vec%0d_usr_rd", idx), 64'(usr_ob_rd), 64'(v.expUsrRd));
    checkOutput($sformatf("vec%0d_err", idx), 64'(tlvp_mrg_err), 64'(v.expErr));
    tick();
    checkOutput($sformatf("vec%0d_err_once", idx), 64'(tlvp_mrg_err), 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, OrdW'(1), 1'b0, OrdW'(0), 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, OrdW'(0), 1'b1, OrdW'(1), 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, OrdW'(1), 1'b1, OrdW'(1), 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, OrdW'(3), 1'b0, OrdW'(0), 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, OrdW'(0), 1'b0, OrdW'(0), 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, OrdW'(2), 1'b1, OrdW'(1), 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, OrdW'(0), 1'b0, OrdW'(0), 1'b0, 1'b0, 1'b0};

    assertReset();
    #1;
    checkOutput("rst_valid", 64'(tlvp_out_valid), 64'd0);
    checkOutput("rst_out", 64'(tlvp_out), 64'd0);
    checkOutput("rst_pt_rd", 64'(pt_ob_rd), 64'd0);
    checkOutput("rst_usr_rd", 64'(usr_ob_rd), 64'd0);
    checkOutput("rst_err", 64'(tlvp_mrg_err), 64'd0);
    checkOutput("rst_wdog", 64'(tlvp_mrg_wdog_err), 64'd0);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

    $display("[TB] ordering sequence");
    assertReset();
    ptQ.push_back(mkWord(1, 32'hA10, 0, 0));
    ptQ.push_back(mkWord(1, 32'hA11, 0, 0));
    ptQ.push_back(mkWord(1, 32'hA12, 1, 0));
    ptQ.push_back(mkWord(3, 32'hA30, 1, 0));
    usrQ.push_back(mkWord(2, 32'hB20, 0, 0));
    usrQ.push_back(mkWord(2, 32'hB21, 1, 0));
    expQ.push_back(mkWord(1, 32'hA10, 0, 0));
    expQ.push_back(mkWord(1, 32'hA11, 0, 0));
    expQ.push_back(mkWord(1, 32'hA12, 1, 0));
    expQ.push_back(mkWord(2, 32'hB20, 0, 0));
    expQ.push_back(mkWord(2, 32'hB21, 1, 0));
    expQ.push_back(mkWord(3, 32'hA30, 1, 0));
    releaseReset();
    runUntil(6, 60);
    compareRx("t1_order");
    checkOutput("t1_pops", 64'(popCount), 64'd6);
    checkOutput("t1_err", 64'(errPulses), 64'd0);
    ptQ.push_back(mkWord(4, 32'hA40, 1, 0));
    expQ.push_back(mkWord(4, 32'hA40, 1, 0));
    updateHeads();
    runUntil(7, 20);
    compareRx("t1_exp_ord4");

    $display("[TB] tlast sequence");
    assertReset();
    ptQ.push_back(mkWord(1, 32'hC10, 1, 0));
    usrQ.push_back(mkWord(2, 32'hD20, 1, 1));
    ptQ.push_back(mkWord(1, 32'hC11, 1, 0));
    expQ.push_back(mkWord(1, 32'hC10, 1, 0));
    expQ.push_back(mkWord(2, 32'hD20, 1, 1));
    expQ.push_back(mkWord(1, 32'hC11, 1, 0));
    releaseReset();
    runUntil(3, 40);
    compareRx("t2_tlast");
    checkOutput("t2_err", 64'(errPulses), 64'd0);

    $display("[TB] backpressure sequence");
    assertReset();
    for (int i = 0; i < 4; i++) begin
      ptQ.push_back(mkWord(1, 32'hE10 + i, (i == 3), 0));
      expQ.push_back(mkWord(1, 32'hE10 + i, (i == 3), 0));
    end
    releaseReset();
    runUntil(1, 20);
    tlvp_out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("t3_hold_valid", 64'(tlvp_out_valid), 64'd1);
      checkOutput("t3_hold_word", 64'(tlvp_out), 64'(mkWord(1, 32'hE11, 0, 0)));
      checkOutput("t3_no_pop", 64'(pt_ob_rd), 64'd0);
      tick();
    end
    tlvp_out_ready = 1'b1;
    runUntil(4, 30);
    compareRx("t3_words");
    checkOutput("t3_pops", 64'(popCount), 64'd4);

    $display("[TB] conflict sequence");
    assertReset();
    ptQ.push_back(mkWord(1, 32'hF10, 0, 0));
    ptQ.push_back(mkWord(1, 32'hF11, 1, 0));
    usrQ.push_back(mkWord(1, 32'hF90, 1, 0));
    expQ.push_back(mkWord(1, 32'hF10, 0, 0));
    expQ.push_back(mkWord(1, 32'hF11, 1, 0));
    releaseReset();
    tick();
    checkOutput("t4_conflict_err", 64'(tlvp_mrg_err), 64'd1);
    checkOutput("t4_pt_first", 64'(pt_ob_rd), 64'd1);
    checkOutput("t4_usr_idle", 64'(usr_ob_rd), 64'd0);
    for (int k = 0; k < 20; k++) tick();
    compareRx("t4_words");
    checkOutput("t4_err_pulses", 64'(errPulses), 64'd2);
    checkOutput("t4_pops", 64'(popCount), 64'd2);

    $display("[TB] stall sequence");
    assertReset();
    for (int i = 1; i <= 3; i++) begin
      ptQ.push_back(mkWord(i, 32'h500 + i, 1, 0));
      expQ.push_back(mkWord(i, 32'h500 + i, 1, 0));
    end
    usrQ.push_back(mkWord(5, 32'h555, 1, 0));
    releaseReset();
    runUntil(3, 40);
    compareRx("t5_prefix");
    popCount = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 2) checkOutput("t5_wdog_early", 64'(tlvp_mrg_wdog_err), 64'd0);
    end
`ifdef CR_TLVP_MRG_WDOG_EN
    checkOutput("t5_wdog_set", 64'(tlvp_mrg_wdog_err), 64'd1);
`else
    checkOutput("t5_wdog_off", 64'(tlvp_mrg_wdog_err), 64'd0);
`endif
    checkOutput("t5_no_pops", 64'(popCount), 64'd0);
    checkOutput("t5_err", 64'(errPulses), 64'd0);

    $display("[TB] reset mid-TLV sequence");
    assertReset();
    ptQ.push_back(mkWord(1, 32'h610, 1, 0));
    usrQ.push_back(mkWord(2, 32'h720, 0, 0));
    usrQ.push_back(mkWord(2, 32'h721, 0, 0));
    usrQ.push_back(mkWord(2, 32'h722, 1, 0));
    expQ.push_back(mkWord(1, 32'h610, 1, 0));
    expQ.push_back(mkWord(2, 32'h720, 0, 0));
    releaseReset();
    runUntil(2, 30);
    checkOutput("t6_mid_word", 64'(tlvp_out), 64'(mkWord(2, 32'h721, 0, 0)));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 64'(tlvp_out_valid), 64'd0);
    checkOutput("t6_rst_out", 64'(tlvp_out), 64'd0);
    checkOutput("t6_rst_usr_rd", 64'(usr_ob_rd), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    popCount = 0;
    for (int k = 0; k < 4; k++) tick();
    checkOutput("t6_wait_pops", 64'(popCount), 64'd0);
    checkOutput("t6_wait_err", 64'(errPulses), 64'd0);
    ptQ.push_back(mkWord(1, 32'h611, 1, 0));
    expQ.push_back(mkWord(1, 32'h611, 1, 0));
    expQ.push_back(mkWord(2, 32'h722, 1, 0));
    updateHeads();
    runUntil(4, 30);
    compareRx("t6_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
